// File: rtl/i2c_reg_poller.sv
// i2c_reg_poller
//   Autonomous register sequencer in front of the i2c_wrapper command port.
//   Polls NUM_BYTES consecutive registers, one byte per master transaction,
//   either every PERIOD_CYCLES while enable is high or on trigger. The bytes
//   are published atomically on result. Single-byte register writes are
//   queued (one deep) and take priority over polls. Every failed attempt
//   (NACK or timeout) is counted and retried up to MAX_RETRIES times.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   enable, trigger    periodic poll enable, one-shot poll request
//   wr_req/addr/data   single-byte write request; wr_ack pulses on success
//   m_*                command/status interface to the I2C master
//   result             last complete poll, byte 0 (REG_BASE) in the MSBs
//   result_valid       one-cycle pulse when result updates
//   busy               sequencer not idle
//   fault              one-cycle pulse when an operation is abandoned
//   err_count          failed attempts, saturating at 255
module i2c_reg_poller #(
  parameter int         CLK_FREQ       = 100_000_000,
  parameter int         POLL_MS        = 250,
  parameter int         NUM_BYTES      = 2,
  parameter logic [6:0] DEV_ADDR       = 7'b1001011,
  parameter logic [7:0] REG_BASE       = 8'h00,
  parameter int         MAX_RETRIES    = 3,
  parameter int         TIMEOUT_CYCLES = 100_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   trigger,
  input  logic                   wr_req,
  input  logic [7:0]             wr_addr,
  input  logic [7:0]             wr_data,
  output logic                   wr_ack,
  output logic                   m_start,
  output logic                   m_rd_wr,
  output logic [7:0]             m_reg_addr,
  output logic [6:0]             m_bus_addr,
  output logic [7:0]             m_wdata,
  input  logic [7:0]             m_rdata,
  input  logic                   m_busy,
  input  logic                   m_done,
  input  logic                   m_error,
  output logic [NUM_BYTES*8-1:0] result,
  output logic                   result_valid,
  output logic                   busy,
  output logic                   fault,
  output logic [7:0]             err_count
);

  localparam int PERIOD_CYCLES = (CLK_FREQ / 1000) * POLL_MS;
  localparam int PW = $clog2(PERIOD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    RETRY_MAX = 3'(MAX_RETRIES);
  localparam logic [1:0]    LAST_IDX  = 2'(NUM_BYTES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, PUBLISH} state_t;

  // Operation currently presented to the master; held from ISSUE through WAIT.
  typedef struct packed {
    logic       rd;
    logic [7:0] addr;
    logic [7:0] data;
  } op_t;

  state_t state, state_nxt;
  op_t    op;

  logic                   poll_pend, wr_pend;
  logic [7:0]             wr_addr_q, wr_data_q;
  logic [PW-1:0]          per_cnt;
  logic                   per_tick;
  logic [TW-1:0]          to_cnt;
  logic [2:0]             retries;
  logic [1:0]             idx;
  logic [NUM_BYTES*8-1:0] shadow, rd_ext;

  logic start_wr, start_rd, issue, fail, retry, rd_ok, wr_ok;

  assign per_tick   = enable && (per_cnt == PER_LAST);
  assign rd_ext     = (NUM_BYTES*8)'(m_rdata);
  assign m_bus_addr = DEV_ADDR;
  assign m_rd_wr    = op.rd;
  assign m_reg_addr = op.addr;
  assign m_wdata    = op.data;
  assign busy       = (state != IDLE);
  // Gated by rst so a reset landing on an ISSUE cycle never leaks a start.
  assign m_start    = issue && !rst;

  always_comb begin
    state_nxt = state;
    start_wr  = 1'b0;
    start_rd  = 1'b0;
    issue     = 1'b0;
    fail      = 1'b0;
    retry     = 1'b0;
    rd_ok     = 1'b0;
    wr_ok     = 1'b0;
    case (state)
      IDLE: begin
        if (wr_pend) begin
          start_wr  = 1'b1;
          state_nxt = ISSUE;
        end else if (poll_pend) begin
          start_rd  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (!m_busy) begin
          issue     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // Error beats done; a done landing on the last timeout cycle is
        // still accepted rather than thrown away.
        if (m_error || (!m_done && to_cnt == TO_LAST)) begin
          fail = 1'b1;
          if (retries < RETRY_MAX) begin
            retry     = 1'b1;
            state_nxt = ISSUE;
          end else begin
            state_nxt = IDLE;
          end
        end else if (m_done) begin
          if (op.rd) begin
            rd_ok     = 1'b1;
            state_nxt = (idx == LAST_IDX) ? PUBLISH : ISSUE;
          end else begin
            wr_ok     = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      PUBLISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      op           <= '0;
      poll_pend    <= 1'b0;
      wr_pend      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      per_cnt      <= '0;
      to_cnt       <= '0;
      retries      <= '0;
      idx          <= '0;
      shadow       <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      wr_ack       <= 1'b0;
      fault        <= 1'b0;
      err_count    <= '0;
    end else begin
      state        <= state_nxt;
      wr_ack       <= 1'b0;
      fault        <= 1'b0;
      result_valid <= 1'b0;

      if (!enable || per_cnt == PER_LAST) per_cnt <= '0;
      else                                per_cnt <= per_cnt + 1'b1;

      // A request arriving in the very cycle a poll is taken still earns a
      // follow-up poll, so set has priority over the service clear.
      if (per_tick || trigger) poll_pend <= 1'b1;
      else if (start_rd)       poll_pend <= 1'b0;

      // One-deep write slot: requests while it is occupied are dropped.
      if (!wr_pend) begin
        if (wr_req) begin
          wr_pend   <= 1'b1;
          wr_addr_q <= wr_addr;
          wr_data_q <= wr_data;
        end
      end else if (wr_ok || (fail && !retry && !op.rd)) begin
        wr_pend <= 1'b0;
      end

      if (start_wr) op <= '{rd: 1'b0, addr: wr_addr_q, data: wr_data_q};
      if (start_rd) begin
        op     <= '{rd: 1'b1, addr: REG_BASE, data: 8'h00};
        idx    <= '0;
        shadow <= '0;
      end

      if (issue)              to_cnt <= '0;
      else if (state == WAIT) to_cnt <= to_cnt + 1'b1;

      if (fail) begin
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        if (retry) begin
          retries <= retries + 3'd1;
        end else begin
          retries <= '0;
          fault   <= 1'b1;
          shadow  <= '0;
        end
      end

      // Bytes arrive in index order, so shifting left leaves byte 0 on top.
      if (rd_ok) begin
        shadow  <= (shadow << 8) | rd_ext;
        retries <= '0;
        if (idx != LAST_IDX) begin
          idx     <= idx + 2'd1;
          op.addr <= op.addr + 8'd1;
        end
      end

      if (wr_ok) begin
        wr_ack  <= 1'b1;
        retries <= '0;
      end

      if (state == PUBLISH) begin
        result       <= shadow;
        result_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_poller.sv
// Two poller instances share one clock: side 0 (REG_BASE 00, 3 retries)
// and side 1 (REG_BASE FF, 1 retry); both use a 100-cycle period and a
// 50-cycle timeout. Each side has a simple I2C master model and a monitor
// that compares every m_start and result_valid against queues filled by
// the stimulus sequence.
module tb_i2c_reg_poller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Stimulus controls, written only by the main sequence.
  logic       rst[2], enable[2], trigger[2], wr_req[2], no_resp[2];
  logic [7:0] wr_addr[2], wr_data[2], nack_addr[2];
  int         nack_total[2];
  logic [7:0] rdq[2][$];
  logic [16:0] exp_txn[2][$];  // {rd, reg_addr, wdata (0 for reads)}
  int         exp_res[2][$];

  // Status mirrored out of each side.
  int         rv_w[2], ack_w[2], fault_w[2], start_w[2], extra_w[2];
  logic       busy_w[2];
  logic [7:0] err_w[2];
  logic [15:0] res_w[2];

  for (genvar k = 0; k < 2; k++) begin : g_side
    logic        wr_ack, m_start, m_rd_wr, m_busy, m_done, m_error;
    logic        result_valid, busy, fault;
    logic [7:0]  m_reg_addr, m_wdata, m_rdata, err_count;
    logic [6:0]  m_bus_addr;
    logic [15:0] result;
    int rv_cnt = 0, ack_cnt = 0, fault_cnt = 0, start_n = 0, extra = 0;
    int tp = 0, rp2 = 0, rv_cyc = 0, ack_cyc = 0;
    int start_cyc[$];

    i2c_reg_poller #(
      .CLK_FREQ(100_000), .POLL_MS(1), .NUM_BYTES(2), .DEV_ADDR(7'h4B),
      .REG_BASE(k == 0 ? 8'h00 : 8'hFF), .MAX_RETRIES(k == 0 ? 3 : 1),
      .TIMEOUT_CYCLES(50)
    ) dut (
      .clk(clk), .rst(rst[k]), .enable(enable[k]), .trigger(trigger[k]),
      .wr_req(wr_req[k]), .wr_addr(wr_addr[k]), .wr_data(wr_data[k]),
      .wr_ack(wr_ack), .m_start(m_start), .m_rd_wr(m_rd_wr),
      .m_reg_addr(m_reg_addr), .m_bus_addr(m_bus_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_busy(m_busy), .m_done(m_done), .m_error(m_error),
      .result(result), .result_valid(result_valid), .busy(busy),
      .fault(fault), .err_count(err_count)
    );

    assign rv_w[k]    = rv_cnt;
    assign ack_w[k]   = ack_cnt;
    assign fault_w[k] = fault_cnt;
    assign start_w[k] = start_n;
    assign extra_w[k] = extra;
    assign busy_w[k]  = busy;
    assign err_w[k]   = err_count;
    assign res_w[k]   = result;

    // Master model: busy for 4 cycles after a start, then done or error.
    initial begin
      logic       rd;
      logic [7:0] a;
      int         rp, nacks;
      rp = 0; nacks = 0;
      m_busy = 1'b0; m_done = 1'b0; m_error = 1'b0; m_rdata = 8'h00;
      forever begin
        @(negedge clk);
        if (m_start && !no_resp[k]) begin
          rd = m_rd_wr;
          a  = m_reg_addr;
          @(posedge clk); #1 m_busy = 1'b1;
          repeat (3) @(posedge clk);
          #1;
          if (a == nack_addr[k] && nacks < nack_total[k]) begin
            m_error = 1'b1;
            nacks++;
          end else begin
            m_done = 1'b1;
            if (rd) begin
              m_rdata = (rp < rdq[k].size()) ? rdq[k][rp] : 8'hEE;
              rp++;
            end
          end
          @(posedge clk); #1;
          m_done = 1'b0; m_error = 1'b0; m_busy = 1'b0;
        end
      end
    end

    // Monitor / scoreboard.
    initial forever begin
      @(negedge clk);
      if (m_start) begin
        start_cyc.push_back(cyc);
        start_n++;
        if (tp < exp_txn[k].size())
          chk($sformatf("txn%0d_%0d", k, tp),
              {m_rd_wr, m_reg_addr, (m_rd_wr ? 8'h00 : m_wdata)}, exp_txn[k][tp]);
        else
          extra++;
        tp++;
      end
      if (result_valid) begin
        rv_cnt++;
        rv_cyc = cyc;
        if (rp2 < exp_res[k].size())
          chk($sformatf("result%0d_%0d", k, rp2), result, exp_res[k][rp2]);
        else
          extra++;
        rp2++;
      end
      if (wr_ack) begin ack_cnt++; ack_cyc = cyc; end
      if (fault) fault_cnt++;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue one expected 2-byte poll on side k with device bytes b0, b1.
  task automatic exp_poll(int k, logic [7:0] b0, logic [7:0] b1);
    logic [7:0] base;
    logic [7:0] base1;
    base  = (k == 0) ? 8'h00 : 8'hFF;
    base1 = base + 8'd1;
    rdq[k].push_back(b0);
    rdq[k].push_back(b1);
    exp_txn[k].push_back({1'b1, base, 8'h00});
    exp_txn[k].push_back({1'b1, base1, 8'h00});
    exp_res[k].push_back({16'h0, b0, b1});
  endtask

  function automatic int stat(int k, int sel);
    case (sel)
      0:       return rv_w[k];
      1:       return ack_w[k];
      2:       return fault_w[k];
      default: return start_w[k];
    endcase
  endfunction

  // Bounded wait for a side-k counter to reach target.
  task automatic wait_for(string name, int k, int sel, int target, int budget);
    int t;
    t = 0;
    while (stat(k, sel) < target && t < budget) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk(name, stat(k, sel), target);
  endtask

  task automatic pulse_trigger(int k);
    trigger[k] = 1'b1;
    tick(1);
    trigger[k] = 1'b0;
  endtask

  initial begin
    int c0, gap;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; enable[k] = 1'b0; trigger[k] = 1'b0; wr_req[k] = 1'b0;
      wr_addr[k] = 8'h00; wr_data[k] = 8'h00; no_resp[k] = 1'b0;
      nack_addr[k] = 8'h00; nack_total[k] = 0;
    end
    tick(3);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_busy",     g_side[0].busy, 0);
    chk("rst_start",    g_side[0].m_start, 0);
    chk("rst_result",   g_side[0].result, 0);
    chk("rst_err",      g_side[0].err_count, 0);
    chk("rst_bus_addr", g_side[0].m_bus_addr, 7'h4B);
    chk("rst_busy1",    g_side[1].busy, 0);
    tick(1);

    // Periodic polling: two polls, starts 100 cycles apart
    exp_poll(0, 8'h0C, 8'h80);
    exp_poll(0, 8'h12, 8'h34);
    enable[0] = 1'b1;
    wait_for("poll1_done", 0, 0, 1, 300);
    wait_for("poll2_done", 0, 0, 2, 300);
    enable[0] = 1'b0;
    chk("poll_period", g_side[0].start_cyc[2] - g_side[0].start_cyc[0], 100);
    chk("poll_err0", err_w[0], 0);

    // Triggers during an active poll coalesce into one follow-up poll
    exp_poll(0, 8'hAB, 8'hCD);
    exp_poll(0, 8'h11, 8'h22);
    pulse_trigger(0);
    tick(3);
    chk("busy_in_poll", busy_w[0], 1);
    for (int i = 0; i < 3; i++) begin
      pulse_trigger(0);
      tick(1);
    end
    wait_for("coalesce_done", 0, 0, 4, 300);
    tick(60);
    chk("coalesce_count", rv_w[0], 4);
    chk("coalesce_err", err_w[0], 0);

    // Write and poll requested together: write first, start 2 cycles later
    exp_txn[0].push_back({1'b0, 8'h03, 8'h5A});
    exp_poll(0, 8'h55, 8'h66);
    c0 = cyc;
    wr_req[0] = 1'b1; wr_addr[0] = 8'h03; wr_data[0] = 8'h5A; trigger[0] = 1'b1;
    tick(1);
    wr_req[0] = 1'b0; trigger[0] = 1'b0;
    wait_for("wr_ack", 0, 1, 1, 200);
    wait_for("wr_then_poll", 0, 0, 5, 200);
    chk("start_latency", g_side[0].start_cyc[8] - c0, 2);
    chk("ack_before_result", int'(g_side[0].ack_cyc < g_side[0].rv_cyc), 1);

    // Byte 1 NACKed twice, then succeeds on the second retry
    nack_addr[0] = 8'h01; nack_total[0] = 2;
    rdq[0].push_back(8'h77);
    rdq[0].push_back(8'h88);
    exp_txn[0].push_back({1'b1, 8'h00, 8'h00});
    for (int i = 0; i < 3; i++) exp_txn[0].push_back({1'b1, 8'h01, 8'h00});
    exp_res[0].push_back(32'h7788);
    pulse_trigger(0);
    wait_for("retry_done", 0, 0, 6, 400);
    chk("retry_err", err_w[0], 2);
    chk("retry_nofault", fault_w[0], 0);

    // Side 1: address wrap FF -> 00
    exp_poll(1, 8'hA5, 8'h5A);
    pulse_trigger(1);
    wait_for("wrap_done", 1, 0, 1, 200);

    // Side 1: no response, one retry, then fault; result kept
    no_resp[1] = 1'b1;
    exp_txn[1].push_back({1'b1, 8'hFF, 8'h00});
    exp_txn[1].push_back({1'b1, 8'hFF, 8'h00});
    pulse_trigger(1);
    wait_for("timeout_fault", 1, 2, 1, 400);
    chk("timeout_err", err_w[1], 2);
    chk("timeout_result_kept", res_w[1], 16'hA55A);
    chk("timeout_idle", busy_w[1], 0);
    // 50 cycles of waiting, plus the ISSUE cycle of the retry
    gap = g_side[1].start_cyc[3] - g_side[1].start_cyc[2];
    chk("timeout_gap", int'(gap >= 50 && gap <= 51), 1);

    // Side 1: reset while waiting on the master
    exp_txn[1].push_back({1'b1, 8'hFF, 8'h00});
    pulse_trigger(1);
    tick(5);
    chk("pre_rst_busy", busy_w[1], 1);
    rst[1] = 1'b1;
    tick(1);
    rst[1] = 1'b0;
    @(negedge clk);
    chk("post_rst_busy",   g_side[1].busy, 0);
    chk("post_rst_result", g_side[1].result, 0);
    chk("post_rst_err",    g_side[1].err_count, 0);
    chk("post_rst_addr",   g_side[1].m_reg_addr, 0);
    tick(10);
    chk("post_rst_nostart", start_w[1], 5);

    chk("extra0", extra_w[0], 0);
    chk("extra1", extra_w[1], 0);
    chk("txns0_used", g_side[0].tp, exp_txn[0].size());
    chk("txns1_used", g_side[1].tp, exp_txn[1].size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2c_reg_poller.md
Name: i2c_reg_poller

Overview:
- Autonomous I2C register sequencer that sits between board-level glue and the existing I2C master (i2c_wrapper command interface). It replaces button-driven single-byte transfers.
- Periodically, or on demand, reads NUM_BYTES consecutive device registers, one byte per master transaction, and publishes them atomically as one wide word.
- Arbitrates single-byte register writes, with retry, timeout and error accounting.
- Typical use: polling the on-board temperature sensor (16-bit reading) for display.

Parameters:
- CLK_FREQ, 100_000_000, clock frequency in Hz.
- POLL_MS, 250, poll period in ms. PERIOD_CYCLES = (CLK_FREQ/1000)*POLL_MS.
- NUM_BYTES, 2, bytes per poll (1..4).
- DEV_ADDR, 7'b1001011, 7-bit I2C device address driven on m_bus_addr.
- REG_BASE, 8'h00, first register address of a poll.
- MAX_RETRIES, 3, extra attempts per transaction after a failure (0..7).
- TIMEOUT_CYCLES, 100_000, max cycles waiting for m_done/m_error.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  periodic polling enable
- trigger  in  1  one-cycle request for an immediate poll
- wr_req  in  1  one-cycle single-byte write request
- wr_addr  in  8  register address for write
- wr_data  in  8  data for write
- wr_ack  out  1  one-cycle pulse: write completed without error
- m_start  out  1  one-cycle start to master
- m_rd_wr  out  1  1=read, 0=write
- m_reg_addr  out  8  register address to master
- m_bus_addr  out  7  constant DEV_ADDR
- m_wdata  out  8  write data to master
- m_rdata  in  8  read data from master, valid with m_done
- m_busy  in  1  master busy
- m_done  in  1  one-cycle transaction success
- m_error  in  1  one-cycle transaction failure (NACK)
- result  out  NUM_BYTES*8  last complete poll; byte 0 (REG_BASE) in MSBs
- result_valid  out  1  one-cycle pulse when result updates
- busy  out  1  high whenever state != IDLE
- fault  out  1  one-cycle pulse when an operation is abandoned
- err_count  out  8  failed attempts, saturates at 255

Behaviour:
- Reset values: all outputs 0 except m_bus_addr=DEV_ADDR. Period counter, pending flags, retry count, byte index and shadow buffer cleared. FSM goes to IDLE.
- Reset mid-operation aborts immediately. No m_start is issued in the reset cycle or the cycle after it.
- Period counter:
  - Counts only while enable=1; cleared while enable=0.
  - At PERIOD_CYCLES-1 it wraps to 0 and sets poll_pend.
  - trigger also sets poll_pend.
  - Multiple requests arriving before service coalesce into one poll.
- Write capture:
  - wr_req is captured (wr_pend, wr_addr, wr_data latched) in any state if wr_pend=0.
  - If wr_pend=1, the new request is ignored.
- FSM states: IDLE, ISSUE, WAIT, PUBLISH.
- IDLE:
  - If wr_pend: start a write op; priority over poll_pend.
  - Else if poll_pend: start a poll with idx=0 and clear poll_pend.
  - Move to ISSUE the next cycle.
- ISSUE:
  - m_rd_wr, m_reg_addr and m_wdata are driven here and held stable until WAIT exits.
  - Read address is REG_BASE+idx, modulo 256 (wraps past 8'hFF to 8'h00).
  - When m_busy=0: assert m_start for exactly one cycle, clear the timeout counter, go to WAIT.
  - Otherwise stay in ISSUE.
- WAIT:
  - m_error, or timeout counter reaching TIMEOUT_CYCLES-1, is a failure. If m_done and m_error are high in the same cycle, error wins.
  - On failure: err_count += 1 (saturating). If retries < MAX_RETRIES, increment retries and return to ISSUE with the same idx. Otherwise pulse fault, discard the shadow buffer, leave result unchanged, clear wr_pend if this was a write, and go to IDLE.
  - On m_done for a read: store m_rdata into shadow byte idx and clear retries. If idx=NUM_BYTES-1 go to PUBLISH, else increment idx and go to ISSUE.
  - On m_done for a write: pulse wr_ack, clear wr_pend and retries, go to IDLE.
- PUBLISH: copy the shadow buffer to result and pulse result_valid in the same cycle, then go to IDLE. result never shows a partial poll.
- Latency: the first m_start comes 2 cycles after the cycle poll_pend/wr_pend is set while IDLE with m_busy=0.
- Concurrency:
  - enable deasserted mid-poll: the poll completes.
  - trigger or period tick during an operation sets poll_pend, serviced afterwards.
  - wr_req during a poll waits; the poll is not preempted.

Test Plan:
- CLK_FREQ=100_000, POLL_MS=1, NUM_BYTES=2, enable=1; model returns 8'h0C then 8'h80 -> reads reg 8'h00 then 8'h01; result=16'h0C80 with result_valid one cycle; next poll starts 100 cycles after the first tick.
- trigger pulsed 3 times during an active poll -> exactly one additional poll follows; err_count stays 0.
- wr_req with wr_addr=8'h03, wr_data=8'h5A arriving simultaneously with poll_pend -> write issued first (m_rd_wr=0, m_reg_addr=8'h03, m_wdata=8'h5A), wr_ack pulse, then poll.
- Model NACKs byte 1 twice, then succeeds (MAX_RETRIES=3) -> err_count=2, m_reg_addr=8'h01 on each retry, no fault, result updated.
- Model never responds (TIMEOUT_CYCLES=50), MAX_RETRIES=1 -> two attempts 50 cycles apart, fault pulse, err_count=2, result holds its previous value, busy falls.
- REG_BASE=8'hFF, NUM_BYTES=2 -> addresses 8'hFF then 8'h00. rst asserted mid-WAIT -> all outputs reset next cycle and no m_start for 2 cycles.
